// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the integer (and future FP) register files.
//   REG_ZERO        architecturally hardwired zero register index
//   DEFAULT_DATA_W  default register width
//   DEFAULT_ADDR_W  default register address width
//   TRACE_PC_W      width of the per-write-port instruction address used by trace
package regfile_pkg;

   localparam int unsigned DEFAULT_DATA_W = 32;
   localparam int unsigned DEFAULT_ADDR_W = 5;
   localparam int unsigned REG_ZERO       = 0;
   localparam int unsigned TRACE_PC_W     = 32;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits for hazard detection.
//   clk         rising-edge clock
//   reset       synchronous, active-low
//   alloc_en    issuing instruction reserves alloc_addr as its destination
//   alloc_addr  destination being reserved
//   flush       clear every pending bit (pipeline squash), alloc ignored
//   wr_en       writeback enables, one per write port
//   wr_addr     writeback addresses, packed, port 0 in the LSBs
//   rd_addr     read addresses, packed, port 0 in the LSBs
//   rd_busy     read register has an outstanding producer (combinational)
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned NUM_WR = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alloc_en,
   input  logic [ADDR_W-1:0]        alloc_addr,
   input  logic                     flush,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]        rd_busy
);

   localparam int unsigned NUM_REGS = 1 << ADDR_W;

   logic [NUM_REGS-1:0] pend;
   logic [NUM_REGS-1:0] pend_next;

   // Pending state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         pend <= '0;
      end else begin
         pend <= pend_next;
      end
   end

   // Next-state: flush beats alloc, alloc beats writeback clear
   always_comb begin
      pend_next = pend;
      if (flush) begin
         pend_next = '0;
      end else begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO))) begin
               pend_next[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
            end
         end
         // A new producer supersedes a writeback of the old one in the same cycle
         if (alloc_en && (alloc_addr != ADDR_W'(REG_ZERO))) begin
            pend_next[alloc_addr] = 1'b1;
         end
      end
      pend_next[REG_ZERO] = 1'b0;
   end

   // Busy unless the producer is writing back this very cycle (value is bypassed)
   always_comb begin
      logic [ADDR_W-1:0] ra;
      logic              wr_hit;
      rd_busy = '0;
      ra      = '0;
      wr_hit  = 1'b0;
      for (int p = 0; p < NUM_RD; p++) begin
         ra     = rd_addr[p*ADDR_W +: ADDR_W];
         wr_hit = 1'b0;
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == ra)) begin
               wr_hit = 1'b1;
            end
         end
         rd_busy[p] = pend[ra] & ~wr_hit;
      end
   end

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port GPR file with same-cycle write bypass and pending scoreboard.
//   clk         rising-edge clock
//   reset       synchronous, active-low
//   rd_addr     read addresses, packed, port 0 in the LSBs
//   rd_data     read data, combinational, bypassed from same-cycle writes
//   rd_busy     read register has an outstanding producer
//   wr_en       write enables (higher port index wins on address conflict)
//   wr_addr     write addresses, packed
//   wr_data     write data, packed
//   wr_pc       instruction address per write port, trace only
//   alloc_en    reserve alloc_addr as a pending destination
//   alloc_addr  destination being reserved
//   flush       clear all pending bits
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W,
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned NUM_WR = 1,
   parameter int unsigned TRACE  = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
   output logic [NUM_RD*DATA_W-1:0]     rd_data,
   output logic [NUM_RD-1:0]            rd_busy,
   input  logic [NUM_WR-1:0]            wr_en,
   input  logic [NUM_WR*ADDR_W-1:0]     wr_addr,
   input  logic [NUM_WR*DATA_W-1:0]     wr_data,
   input  logic [NUM_WR*TRACE_PC_W-1:0] wr_pc,
   input  logic                         alloc_en,
   input  logic [ADDR_W-1:0]            alloc_addr,
   input  logic                         flush
);

   localparam int unsigned NUM_REGS = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [NUM_WR-1:0] wr_win;

   // A write is effective when enabled, nonzero, and not overridden by a higher port
   always_comb begin
      wr_win = '0;
      for (int w = 0; w < NUM_WR; w++) begin
         wr_win[w] = wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO));
         for (int j = w + 1; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == wr_addr[w*ADDR_W +: ADDR_W])) begin
               wr_win[w] = 1'b0;
            end
         end
      end
   end

   // Storage array; register 0 is never written so it stays at its reset value
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_win[w]) begin
               regs[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Read muxes: zero register, then highest matching write port, then storage
   always_comb begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rv;
      rd_data = '0;
      ra      = '0;
      rv      = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         ra = rd_addr[p*ADDR_W +: ADDR_W];
         rv = regs[ra];
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == ra)) begin
               rv = wr_data[w*DATA_W +: DATA_W];
            end
         end
         if (ra == ADDR_W'(REG_ZERO)) begin
            rv = '0;
         end
         rd_data[p*DATA_W +: DATA_W] = rv;
      end
   end

   regfile_scoreboard #(
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD),
      .NUM_WR (NUM_WR)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .alloc_en   (alloc_en),
      .alloc_addr (alloc_addr),
      .flush      (flush),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .rd_addr    (rd_addr),
      .rd_busy    (rd_busy)
   );

   // Simulation-only commit trace, one line per effective write
`ifndef SYNTHESIS
   if (TRACE != 0) begin : g_trace
      always_ff @(posedge clk) begin
         if (reset) begin
            for (int w = 0; w < NUM_WR; w++) begin
               if (wr_win[w]) begin
                  $display("%d@%08h: $%d <= %08h", $time,
                           wr_pc[w*TRACE_PC_W +: TRACE_PC_W],
                           wr_addr[w*ADDR_W +: ADDR_W],
                           wr_data[w*DATA_W +: DATA_W]);
               end
            end
         end
      end
   end else begin : g_no_trace
      logic unused_pc;
      assign unused_pc = ^wr_pc;
   end
`else
   logic unused_pc;
   assign unused_pc = ^wr_pc;
`endif

endmodule : regfile_mp
